// File: rtl/wb_stage_pkg.sv
// Shared rv32i types for the writeback end of the pipeline:
// load funct3 encodings and the writeback FSM state type.
package wb_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } wb_state_t;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational load-data formatter: picks byte/half/word from the raw
// aligned memory word and extends it.
// Ports: funct3, addr_lo, rdata in; data, misaligned out.
module load_formatter
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
        half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                data       = rdata;
                misaligned = (addr_lo != 2'b00);
            end
            // Undefined load widths are treated like a misaligned access.
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: sole driver of the regfile write port. Retires one
// instruction at a time, waits for dmem on loads, counts retirements.
// Ports: MEM/WB handshake (mem_*), dmem response, rf_* write port,
// instret counter, sticky err flag.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_rd,
    input  logic             mem_is_load,
    input  logic [2:0]       mem_funct3,
    input  logic [1:0]       mem_addr_lo,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic             dmem_resp,
    input  logic [XLEN-1:0]  dmem_rdata,
    output logic             rf_load,
    output logic [4:0]       rf_dest,
    output logic [XLEN-1:0]  rf_in,
    output logic [CNT_W-1:0] instret,
    output logic             err
);

    wb_state_t        state_q, state_d;
    logic [4:0]       ld_rd_q, ld_rd_d;
    logic             ld_we_q, ld_we_d;
    logic [2:0]       ld_f3_q, ld_f3_d;
    logic [1:0]       ld_lo_q, ld_lo_d;
    logic             rf_load_q, rf_load_d;
    logic [4:0]       rf_dest_q, rf_dest_d;
    logic [XLEN-1:0]  rf_in_q, rf_in_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             err_q, err_d;

    logic [XLEN-1:0]  fmt_data;
    logic             fmt_mis;

    load_formatter #(.XLEN(XLEN)) u_fmt (
        .funct3     (ld_f3_q),
        .addr_lo    (ld_lo_q),
        .rdata      (dmem_rdata),
        .data       (fmt_data),
        .misaligned (fmt_mis)
    );

    assign mem_ready = (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        ld_rd_d   = ld_rd_q;
        ld_we_d   = ld_we_q;
        ld_f3_d   = ld_f3_q;
        ld_lo_d   = ld_lo_q;
        rf_load_d = 1'b0;
        rf_dest_d = rf_dest_q;
        rf_in_d   = rf_in_q;
        instret_d = instret_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    if (mem_is_load) begin
                        ld_rd_d = mem_rd;
                        ld_we_d = mem_regwrite;
                        ld_f3_d = mem_funct3;
                        ld_lo_d = mem_addr_lo;
                        state_d = WAIT_LOAD;
                    end else begin
                        instret_d = instret_q + CNT_W'(1);
                        // Dest/data only move when a write is issued.
                        if (mem_regwrite && (mem_rd != 5'd0)) begin
                            rf_load_d = 1'b1;
                            rf_dest_d = mem_rd;
                            rf_in_d   = mem_alu_result;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_resp) begin
                    state_d   = IDLE;
                    instret_d = instret_q + CNT_W'(1);
                    if (fmt_mis) begin
                        err_d = 1'b1;
                    end else if (ld_we_q && (ld_rd_q != 5'd0)) begin
                        rf_load_d = 1'b1;
                        rf_dest_d = ld_rd_q;
                        rf_in_d   = fmt_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ld_rd_q   <= '0;
            ld_we_q   <= 1'b0;
            ld_f3_q   <= '0;
            ld_lo_q   <= '0;
            rf_load_q <= 1'b0;
            rf_dest_q <= '0;
            rf_in_q   <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_rd_q   <= ld_rd_d;
            ld_we_q   <= ld_we_d;
            ld_f3_q   <= ld_f3_d;
            ld_lo_q   <= ld_lo_d;
            rf_load_q <= rf_load_d;
            rf_dest_q <= rf_dest_d;
            rf_in_q   <= rf_in_d;
            instret_q <= instret_d;
            err_q     <= err_d;
        end
    end

    assign rf_load = rf_load_q;
    assign rf_dest = rf_dest_q;
    assign rf_in   = rf_in_q;
    assign instret = instret_q;
    assign err     = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_regwrite;
    logic [4:0]  mem_rd;
    logic        mem_is_load;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_alu_result;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        rf_load;
    logic [4:0]  rf_dest;
    logic [31:0] rf_in;
    logic [31:0] instret;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instret = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_regwrite   (mem_regwrite),
        .mem_rd         (mem_rd),
        .mem_is_load    (mem_is_load),
        .mem_funct3     (mem_funct3),
        .mem_addr_lo    (mem_addr_lo),
        .mem_alu_result (mem_alu_result),
        .dmem_resp      (dmem_resp),
        .dmem_rdata     (dmem_rdata),
        .rf_load        (rf_load),
        .rf_dest        (rf_dest),
        .rf_in          (rf_in),
        .instret        (instret),
        .err            (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_valid = 1'b1;
        mem_regwrite = 1'b1;
        mem_rd = 5'd5;
        mem_is_load = 1'b0;
        mem_funct3 = 3'b000;
        mem_addr_lo = 2'b00;
        mem_alu_result = 32'hDEAD_BEEF;
        dmem_resp = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        tick();
        checks++;
        if ({rf_load, rf_dest, rf_in, instret, err} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%h/%h/%h/%b want all 0",
                     rf_load, rf_dest, rf_in, instret, err);
        end
        mem_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (mem_ready !== 1'b1 || rf_load !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready %b load %b want 1 0",
                     mem_ready, rf_load);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res [3];
        res[0] = 32'h11;
        res[1] = 32'h22;
        res[2] = 32'h33;
        mem_regwrite = 1'b1;
        mem_is_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1;
            mem_rd = 5'(i + 1);
            mem_alu_result = res[i];
            checks++;
            if (mem_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, mem_ready);
            end
            tick();
            exp_instret++;
            checks++;
            if (rf_load !== 1'b1 || rf_dest !== 5'(i + 1) ||
                rf_in !== res[i]) begin
                errors++;
                $display("FAIL b2b_write%0d: got %b/%0d/%h want 1/%0d/%h",
                         i, rf_load, rf_dest, rf_in, i + 1, res[i]);
            end
        end
        mem_valid = 1'b0;
        tick();
        checks++;
        if (rf_load !== 1'b0 || instret !== 32'd3) begin
            errors++;
            $display("FAIL b2b_end: load %b instret %0d want 0 3",
                     rf_load, instret);
        end
    endtask

    // Accept a load to rd=7; response comes 4 cycles after accept.
    task automatic test_load(input string name, input logic [2:0] f3,
                             input logic [1:0] lo, input logic [31:0] word,
                             input logic [31:0] exp);
        mem_valid = 1'b1;
        mem_is_load = 1'b1;
        mem_regwrite = 1'b1;
        mem_rd = 5'd7;
        mem_funct3 = f3;
        mem_addr_lo = lo;
        tick();
        mem_valid = 1'b0;
        mem_is_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_ready !== 1'b0 || rf_load !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait%0d: ready %b load %b want 0 0",
                         name, i, mem_ready, rf_load);
            end
            tick();
        end
        dmem_resp = 1'b1;
        dmem_rdata = word;
        tick();
        dmem_resp = 1'b0;
        exp_instret++;
        checks++;
        if (rf_load !== 1'b1 || rf_dest !== 5'd7 || rf_in !== exp ||
            instret !== exp_instret || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_data: got %b/%0d/%h/%0d/%b want 1/7/%h/%0d/1",
                     name, rf_load, rf_dest, rf_in, instret, mem_ready,
                     exp, exp_instret);
        end
        tick();
        checks++;
        if (rf_load !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: load %b want 0", name, rf_load);
        end
    endtask

    task automatic test_rd0_and_stray_resp();
        mem_valid = 1'b1;
        mem_is_load = 1'b0;
        mem_regwrite = 1'b1;
        mem_rd = 5'd0;
        mem_alu_result = 32'h55;
        tick();
        mem_valid = 1'b0;
        exp_instret++;
        checks++;
        if (rf_load !== 1'b0 || instret !== exp_instret) begin
            errors++;
            $display("FAIL rd0: load %b instret %0d want 0 %0d",
                     rf_load, instret, exp_instret);
        end
        dmem_resp = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_resp = 1'b0;
        checks++;
        if (rf_load !== 1'b0 || instret !== exp_instret ||
            mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL stray_resp: load %b instret %0d ready %b want 0 %0d 1",
                     rf_load, instret, mem_ready, exp_instret);
        end
    endtask

    task automatic test_misaligned(input string name, input logic [2:0] f3,
                                   input logic [1:0] lo);
        mem_valid = 1'b1;
        mem_is_load = 1'b1;
        mem_regwrite = 1'b1;
        mem_rd = 5'd8;
        mem_funct3 = f3;
        mem_addr_lo = lo;
        tick();
        mem_valid = 1'b0;
        mem_is_load = 1'b0;
        dmem_resp = 1'b1;
        dmem_rdata = 32'h1234_5678;
        tick();
        dmem_resp = 1'b0;
        exp_instret++;
        checks++;
        if (rf_load !== 1'b0 || err !== 1'b1 || instret !== exp_instret ||
            mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: load %b err %b instret %0d ready %b want 0 1 %0d 1",
                     name, rf_load, err, instret, mem_ready, exp_instret);
        end
    endtask

    task automatic test_err_sticky();
        mem_valid = 1'b1;
        mem_is_load = 1'b0;
        mem_regwrite = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rd = 5'd4;
            mem_alu_result = 32'(i + 32'h40);
            tick();
            exp_instret++;
            checks++;
            if (err !== 1'b1 || rf_load !== 1'b1 ||
                rf_in !== 32'(i + 32'h40)) begin
                errors++;
                $display("FAIL err_sticky%0d: err %b load %b in %h want 1 1 %h",
                         i, err, rf_load, rf_in, i + 32'h40);
            end
        end
        mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        mem_valid = 1'b1;
        mem_is_load = 1'b1;
        mem_regwrite = 1'b1;
        mem_rd = 5'd9;
        mem_funct3 = 3'b010;
        mem_addr_lo = 2'b00;
        tick();
        mem_valid = 1'b0;
        mem_is_load = 1'b0;
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL midload_wait: ready %b want 0", mem_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (instret !== 32'd0 || err !== 1'b0 || rf_load !== 1'b0 ||
            mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL midload_async: instret %0d err %b load %b ready %b want 0 0 0 1",
                     instret, err, rf_load, mem_ready);
        end
        tick();
        rst = 1'b1;
        exp_instret = 0;
        dmem_resp = 1'b1;
        dmem_rdata = 32'hAAAA_5555;
        tick();
        dmem_resp = 1'b0;
        checks++;
        if (rf_load !== 1'b0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL midload_stray: load %b instret %0d want 0 0",
                     rf_load, instret);
        end
        mem_valid = 1'b1;
        mem_rd = 5'd10;
        mem_alu_result = 32'hAB;
        tick();
        mem_valid = 1'b0;
        exp_instret++;
        checks++;
        if (rf_load !== 1'b1 || rf_dest !== 5'd10 || rf_in !== 32'hAB ||
            instret !== 32'd1) begin
            errors++;
            $display("FAIL midload_next: got %b/%0d/%h/%0d want 1/10/ab/1",
                     rf_load, rf_dest, rf_in, instret);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load("lb",  3'b000, 2'd3, 32'h80FF_FF00, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 2'd3, 32'h80FF_FF00, 32'h0000_0080);
        test_load("lhu", 3'b101, 2'd2, 32'h80FF_FF00, 32'h0000_80FF);
        test_load("lh",  3'b001, 2'd0, 32'h1234_8001, 32'hFFFF_8001);
        test_load("lw",  3'b010, 2'd0, 32'h1234_5678, 32'h1234_5678);
        test_rd0_and_stray_resp();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", err);
        end
        test_misaligned("lw_mis", 3'b010, 2'd2);
        test_err_sticky();
        test_reset_mid_load();
        test_misaligned("f3_undef", 3'b011, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
